// File: rtl/wf_done_sequencer_pkg.sv
// Shared issue-stage definitions: wavefront slot geometry and done-sequencer state encoding.
package wf_done_sequencer_pkg;

  localparam int WF_PER_CU    = 40;
  localparam int WF_ID_LENGTH = 6;
  localparam int RETIRE_CNT_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } seq_state_e;

endpackage

// File: rtl/wf_done_sequencer_rr_pick_first.sv
// Rotating-priority pick: first set request at or above ptr, wrapping past NUM_WF-1 to 0.
module rr_pick_first #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6
) (
  input  logic [NUM_WF-1:0] req,
  input  logic [WFID_W-1:0] ptr,
  output logic              found,
  output logic [WFID_W-1:0] idx
);

  localparam logic [WFID_W:0] NUM_WF_W = (WFID_W+1)'(NUM_WF);

  // One extra bit so ptr + offset cannot overflow before the wrap subtract.
  logic [WFID_W:0] slot;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    slot  = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      slot = {1'b0, ptr} + (WFID_W+1)'(i);
      if (slot >= NUM_WF_W) slot = slot - NUM_WF_W;
      if (!found && req[slot[WFID_W-1:0]]) begin
        found = 1'b1;
        idx   = slot[WFID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wf_done_sequencer.sv
// Hands finished wavefront ids to fetch one at a time, round-robin, with a ready/valid handshake.
//
//   state    | meaning
//   ST_IDLE  | no offer pending, fetch_done_valid = 0
//   ST_OFFER | fetch_done_wf_id offered to fetch, held until accepted
module wf_done_sequencer
  import wf_done_sequencer_pkg::*;
#(
  parameter int NUM_WF = WF_PER_CU,
  parameter int WFID_W = WF_ID_LENGTH,
  parameter int CNT_W  = RETIRE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] done_wf_array,
  input  logic              flush,
  input  logic              fetch_done_ready,
  output logic              fetch_done_valid,
  output logic [WFID_W-1:0] fetch_done_wf_id,
  output logic [NUM_WF-1:0] reported_array,
  output logic [CNT_W-1:0]  retired_count
);

  localparam logic [WFID_W-1:0] LAST_ID = WFID_W'(NUM_WF - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  seq_state_e        state;
  logic [WFID_W-1:0] rr_ptr;
  logic [NUM_WF-1:0] held_mask;
  logic [NUM_WF-1:0] cand;
  logic              win_found;
  logic [WFID_W-1:0] win_idx;
  logic [WFID_W-1:0] win_next_ptr;
  logic              handshake;

  always_comb begin
    held_mask = '0;
    if (state == ST_OFFER) held_mask[fetch_done_wf_id] = 1'b1;
  end

  assign cand         = done_wf_array & ~reported_array & ~held_mask;
  assign handshake    = fetch_done_valid & fetch_done_ready;
  assign win_next_ptr = (win_idx == LAST_ID) ? '0 : win_idx + WFID_W'(1);

  rr_pick_first #(
    .NUM_WF (NUM_WF),
    .WFID_W (WFID_W)
  ) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .found (win_found),
    .idx   (win_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_IDLE;
      fetch_done_valid <= 1'b0;
      fetch_done_wf_id <= '0;
      reported_array   <= '0;
      retired_count    <= '0;
      rr_ptr           <= '0;
    end else if (flush) begin
      state            <= ST_IDLE;
      fetch_done_valid <= 1'b0;
      fetch_done_wf_id <= '0;
      reported_array   <= '0;
    end else begin
      // A slot that dropped done re-arms; the accepted slot's set wins over its clear.
      reported_array <= (reported_array & done_wf_array) | (handshake ? held_mask : '0);
      if (handshake && retired_count != CNT_MAX)
        retired_count <= retired_count + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state            <= ST_OFFER;
            fetch_done_valid <= 1'b1;
            fetch_done_wf_id <= win_idx;
            rr_ptr           <= win_next_ptr;
          end
        end
        ST_OFFER: begin
          if (handshake) begin
            if (win_found) begin
              fetch_done_wf_id <= win_idx;
              rr_ptr           <= win_next_ptr;
            end else begin
              state            <= ST_IDLE;
              fetch_done_valid <= 1'b0;
              fetch_done_wf_id <= '0;
            end
          end
        end
        default: begin
          state            <= ST_IDLE;
          fetch_done_valid <= 1'b0;
          fetch_done_wf_id <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wf_done_sequencer.sv
// Directed self-checking bench for wf_done_sequencer with hand-computed expectations.
module tb_wf_done_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] done_wf_array;
  logic        flush;
  logic        fetch_done_ready;
  logic        fetch_done_valid;
  logic [5:0]  fetch_done_wf_id;
  logic [39:0] reported_array;
  logic [15:0] retired_count;

  int total = 0;
  int bad   = 0;

  wf_done_sequencer #(
    .NUM_WF (40),
    .WFID_W (6),
    .CNT_W  (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .done_wf_array    (done_wf_array),
    .flush            (flush),
    .fetch_done_ready (fetch_done_ready),
    .fetch_done_valid (fetch_done_valid),
    .fetch_done_wf_id (fetch_done_wf_id),
    .reported_array   (reported_array),
    .retired_count    (retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] bit40(input int n);
    logic [39:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    done_wf_array = '0;
    fetch_done_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    done_wf_array = '1;
    fetch_done_ready = 1'b1;
    #2;
    total++; if (fetch_done_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", fetch_done_valid); end
    total++; if (fetch_done_wf_id !== 6'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", fetch_done_wf_id); end
    total++; if (reported_array !== 40'd0) begin bad++; $display("FAIL reset_reported: got %h want 0", reported_array); end
    total++; if (retired_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    step();
    total++; if (fetch_done_valid !== 1'b0) begin bad++; $display("FAIL reset_hold_valid: got %0b want 0", fetch_done_valid); end
  endtask

  task automatic test_single();
    do_reset();
    done_wf_array = bit40(5);
    fetch_done_ready = 1'b1;
    step();
    total++; if (fetch_done_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", fetch_done_valid); end
    total++; if (fetch_done_wf_id !== 6'd5) begin bad++; $display("FAIL single_id: got %0d want 5", fetch_done_wf_id); end
    step();
    total++; if (fetch_done_valid !== 1'b0) begin bad++; $display("FAIL single_drop: got %0b want 0", fetch_done_valid); end
    total++; if (fetch_done_wf_id !== 6'd0) begin bad++; $display("FAIL single_id_zero: got %0d want 0", fetch_done_wf_id); end
    total++; if (reported_array !== bit40(5)) begin bad++; $display("FAIL single_reported: got %h want %h", reported_array, bit40(5)); end
    total++; if (retired_count !== 16'd1) begin bad++; $display("FAIL single_count: got %0d want 1", retired_count); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ids [3] = '{6'd3, 6'd10, 6'd39};
    do_reset();
    done_wf_array = bit40(3) | bit40(10) | bit40(39);
    fetch_done_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (fetch_done_valid !== 1'b1 || fetch_done_wf_id !== exp_ids[i]) begin
        bad++; $display("FAIL b2b_id%0d: got v=%0b id=%0d want v=1 id=%0d", i, fetch_done_valid, fetch_done_wf_id, exp_ids[i]);
      end
    end
    step();
    total++; if (fetch_done_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %0b want 0", fetch_done_valid); end
    total++; if (retired_count !== 16'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", retired_count); end
    // pointer wrapped to 0: slot 2 beats slot 5
    done_wf_array = '0;
    step();
    done_wf_array = bit40(2) | bit40(5);
    fetch_done_ready = 1'b0;
    step();
    total++; if (fetch_done_wf_id !== 6'd2) begin bad++; $display("FAIL rr_wrap: got %0d want 2", fetch_done_wf_id); end
    fetch_done_ready = 1'b1;
    step();
    total++; if (fetch_done_wf_id !== 6'd5) begin bad++; $display("FAIL rr_second: got %0d want 5", fetch_done_wf_id); end
    step();
    // pointer now 6: slot 8 beats slot 1
    done_wf_array = '0;
    step();
    done_wf_array = bit40(1) | bit40(8);
    fetch_done_ready = 1'b0;
    step();
    total++; if (fetch_done_wf_id !== 6'd8) begin bad++; $display("FAIL rr_rotate: got %0d want 8", fetch_done_wf_id); end
  endtask

  task automatic test_hold();
    do_reset();
    done_wf_array = bit40(7);
    fetch_done_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      total++; if (fetch_done_valid !== 1'b1 || fetch_done_wf_id !== 6'd7) begin
        bad++; $display("FAIL hold_c%0d: got v=%0b id=%0d want v=1 id=7", c, fetch_done_valid, fetch_done_wf_id);
      end
      if (c == 2) done_wf_array = '0;
    end
    fetch_done_ready = 1'b1;
    step();
    total++; if (fetch_done_valid !== 1'b0) begin bad++; $display("FAIL hold_accept: got %0b want 0", fetch_done_valid); end
    total++; if (retired_count !== 16'd1) begin bad++; $display("FAIL hold_count: got %0d want 1", retired_count); end
    total++; if (reported_array !== bit40(7)) begin bad++; $display("FAIL hold_set_wins: got %h want %h", reported_array, bit40(7)); end
    step();
    total++; if (reported_array !== 40'd0) begin bad++; $display("FAIL hold_clear: got %h want 0", reported_array); end
  endtask

  task automatic test_rearm();
    int reoffers;
    do_reset();
    done_wf_array = bit40(7);
    fetch_done_ready = 1'b1;
    step();
    step();
    reoffers = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (fetch_done_valid !== 1'b0) reoffers++;
    end
    total++; if (reoffers != 0) begin bad++; $display("FAIL rearm_no_reoffer: got %0d offers want 0", reoffers); end
    total++; if (retired_count !== 16'd1) begin bad++; $display("FAIL rearm_count1: got %0d want 1", retired_count); end
    done_wf_array = '0;
    step();
    total++; if (reported_array !== 40'd0) begin bad++; $display("FAIL rearm_cleared: got %h want 0", reported_array); end
    done_wf_array = bit40(7);
    fetch_done_ready = 1'b0;
    step();
    total++; if (fetch_done_valid !== 1'b1 || fetch_done_wf_id !== 6'd7) begin
      bad++; $display("FAIL rearm_reoffer: got v=%0b id=%0d want v=1 id=7", fetch_done_valid, fetch_done_wf_id);
    end
  endtask

  task automatic test_flush();
    do_reset();
    done_wf_array = bit40(12);
    fetch_done_ready = 1'b0;
    step();
    flush = 1'b1;
    fetch_done_ready = 1'b1;
    step();
    total++; if (fetch_done_valid !== 1'b0 || fetch_done_wf_id !== 6'd0) begin
      bad++; $display("FAIL flush_drop: got v=%0b id=%0d want v=0 id=0", fetch_done_valid, fetch_done_wf_id);
    end
    total++; if (reported_array !== 40'd0) begin bad++; $display("FAIL flush_reported: got %h want 0", reported_array); end
    total++; if (retired_count !== 16'd0) begin bad++; $display("FAIL flush_count: got %0d want 0", retired_count); end
    // flush clears reported bits but keeps the pointer
    do_reset();
    done_wf_array = bit40(12) | bit40(20);
    fetch_done_ready = 1'b1;
    step();
    step();
    total++; if (reported_array !== bit40(12) || fetch_done_wf_id !== 6'd20) begin
      bad++; $display("FAIL flush_pre: got rep=%h id=%0d want rep=%h id=20", reported_array, fetch_done_wf_id, bit40(12));
    end
    flush = 1'b1;
    step();
    total++; if (reported_array !== 40'd0 || fetch_done_valid !== 1'b0) begin
      bad++; $display("FAIL flush_clear: got rep=%h v=%0b want rep=0 v=0", reported_array, fetch_done_valid);
    end
    total++; if (retired_count !== 16'd1) begin bad++; $display("FAIL flush_keep_count: got %0d want 1", retired_count); end
    flush = 1'b0;
    fetch_done_ready = 1'b0;
    step();
    total++; if (fetch_done_valid !== 1'b1 || fetch_done_wf_id !== 6'd12) begin
      bad++; $display("FAIL flush_keep_ptr: got v=%0b id=%0d want v=1 id=12", fetch_done_valid, fetch_done_wf_id);
    end
  endtask

  task automatic test_saturate_and_reset();
    int   hs;
    int   cyc;
    logic was_valid;
    do_reset();
    done_wf_array = '1;
    fetch_done_ready = 1'b1;
    hs = 0;
    cyc = 0;
    while (hs < 65539 && cyc < 70000) begin
      was_valid = fetch_done_valid;
      step();
      cyc++;
      if (was_valid) begin
        hs++;
        if (hs == 1000) begin
          total++; if (retired_count !== 16'd1000) begin bad++; $display("FAIL sat_count1000: got %0d want 1000", retired_count); end
        end
        if (hs == 65535) begin
          total++; if (retired_count !== 16'd65535) begin bad++; $display("FAIL sat_count_max: got %0d want 65535", retired_count); end
        end
      end
      done_wf_array = ~reported_array;
    end
    total++; if (hs < 65539) begin bad++; $display("FAIL sat_budget: got %0d handshakes want 65539", hs); end
    total++; if (retired_count !== 16'd65535) begin bad++; $display("FAIL sat_hold: got %0d want 65535", retired_count); end
    fetch_done_ready = 1'b0;
    step();
    total++; if (fetch_done_valid !== 1'b1) begin bad++; $display("FAIL sat_offer_pending: got %0b want 1", fetch_done_valid); end
    #3;
    rst = 1'b0;
    #1;
    total++; if (fetch_done_valid !== 1'b0 || fetch_done_wf_id !== 6'd0) begin
      bad++; $display("FAIL async_rst_offer: got v=%0b id=%0d want v=0 id=0", fetch_done_valid, fetch_done_wf_id);
    end
    total++; if (reported_array !== 40'd0 || retired_count !== 16'd0) begin
      bad++; $display("FAIL async_rst_state: got rep=%h cnt=%0d want 0 0", reported_array, retired_count);
    end
    done_wf_array = '1;
    step();
    rst = 1'b1;
    step();
    total++; if (fetch_done_valid !== 1'b1 || fetch_done_wf_id !== 6'd0) begin
      bad++; $display("FAIL rst_restart: got v=%0b id=%0d want v=1 id=0", fetch_done_valid, fetch_done_wf_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_rearm();
    test_flush();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
